duty_monitor: RTL and testbench
===============================

# duty_monitor

Parametrised multi-channel pulse/duty-cycle monitor, the successor to the single-channel buzz counter used in the Follower benches. Each channel samples a signal and its complement, counts rising edges on both, measures last high time and last period in clocks, and flags loss of complementarity. It sits beside the DUT in system benches, and optionally in the Follower top as a buzzer/PWM self-check, and is fully synchronous to `clk`.

## Interface
Parameters:
- NUM_CH, 2: number of monitored channels (1..16).
- CNT_W, 4: edge-count width per channel; counts saturate.
- TIME_W, 14: high-time and period width per channel; saturate at all-ones.
- DIFF_CHECK, 1: 1 enables the complement check; 0 holds comp_err at 0.
- SKEW_MAX, 1: consecutive cycles sig==sig_n tolerated before an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous clear of all channel state; same effect as rst.
- sig  in  NUM_CH  monitored signals (e.g. buzz).
- sig_n  in  NUM_CH  complement signals (e.g. buzz_n).
- cnt  out  NUM_CH*CNT_W  rising edges of sig; channel i at [i*CNT_W +: CNT_W].
- cnt_n  out  NUM_CH*CNT_W  rising edges of sig_n.
- high_time  out  NUM_CH*TIME_W  clocks sig was high in the last complete high pulse.
- period  out  NUM_CH*TIME_W  clocks between the last two rising edges of sig.
- valid  out  NUM_CH  period is meaningful (two rises seen since clear).
- comp_err  out  NUM_CH  sticky complement-violation flag.

## Operation
- Per channel state: sig_q, sig_n_q, primed, armed, hcnt, pcnt, skew count, plus registered outputs.
- rst or clr: all outputs 0. primed, armed, hcnt, pcnt and skew count are 0. clr has no effect while rst is high (rst dominates).
- Unprimed cycle: sig_q<=sig and sig_n_q<=sig_n. No edge is detected. primed<=1. This blocks false edges after reset or clear.
- rise = sig & ~sig_q; fall = ~sig & sig_q. These are valid only when primed.
- On a rise of sig: cnt+1 (saturating at 2^CNT_W-1) and hcnt<=1.
  - If armed, period<=pcnt and valid<=1.
  - pcnt<=1 and armed<=1.
- A rising edge on sig_n increments cnt_n the same way, independently.
- Outside a rise: hcnt+1 while sig is high; pcnt+1 while armed. Both saturate.
- On a fall while armed: high_time<=hcnt. A partial pulse that was already high at prime time is never recorded.
- Complement check (DIFF_CHECK=1, primed):
  - Skew count increments each cycle sig==sig_n and resets to 0 when they differ.
  - When the count reaches SKEW_MAX+1, comp_err<=1. It stays set until rst or clr.
- Channels are fully independent; simultaneous events on different channels need no arbitration.

## Timing
- Inputs are sampled on posedge clk. Every output is registered and reflects the edge sampled at the same posedge, so it is visible from the next cycle.
- sig sampled high at posedges k..k+H-1 and low at k+H gives high_time=H after posedge k+H.
- Rises sampled at posedges r1 and r2 give period=r2-r1 after posedge r2.
- The first posedge after rst/clr deasserts is the prime cycle. Edges are detected from the second posedge onward.
- Clear mid-pulse discards the in-progress measurement; already-registered outputs go to 0.
- At saturation the counters hold. A saturated hcnt or pcnt is written out as all-ones.

## Structure
- Package duty_mon_pkg holds the default widths (CNT_W_DEF=4, TIME_W_DEF=14) and a `ch_result_t` struct {cnt, cnt_n, high_time, period, valid, comp_err} used by the packing logic.
- Sub-module duty_mon_ch holds one channel's state and logic. The top is a generate loop over NUM_CH that packs the flat output buses.

## Test plan
- Reset release with sig=1 held: cnt=0, valid=0 and high_time=0 for the whole time sig stays high. The first fall records nothing.
- Ch0 square wave, 6250 clocks high and 6250 low, for 3 periods with sig_n=~sig: cnt=3, cnt_n=3, high_time=6250, period=12500, valid=1, comp_err=0.
- Ch1 with 20 pulses at CNT_W=4: cnt saturates at 15. Ch0 is unaffected.
- sig=sig_n=1 held for 1 cycle with SKEW_MAX=1: comp_err stays 0. Held for 2 cycles: comp_err=1, and it stays 1 after the inputs recover until clr.
- clr pulsed mid-high-pulse: all outputs are 0 the next cycle. The next full pulse of 100 clocks gives high_time=100.
- A period longer than 2^TIME_W-1 (TIME_W=8, 300 clocks low): period=255 and valid=1.

Source files
------------

// File: rtl/duty_mon_pkg.sv
// duty_mon_pkg
//   Shared definitions for the duty_monitor block.
//   - CNT_W_DEF / TIME_W_DEF : default edge-count and time-measurement widths.
//   - CNT_W_MAX / TIME_W_MAX : widest values a channel may be built with; the
//     per-channel result struct is sized to these so one type serves every
//     parameterisation. Channels zero-extend into it and the top truncates.
//   - ch_result_t            : one channel's registered results, consumed by the
//     packing logic in the top.
package duty_mon_pkg;

  localparam int CNT_W_DEF  = 4;
  localparam int TIME_W_DEF = 14;
  localparam int CNT_W_MAX  = 16;
  localparam int TIME_W_MAX = 32;

  typedef struct packed {
    logic [CNT_W_MAX-1:0]  cnt;
    logic [CNT_W_MAX-1:0]  cnt_n;
    logic [TIME_W_MAX-1:0] high_time;
    logic [TIME_W_MAX-1:0] period;
    logic                  valid;
    logic                  comp_err;
  } ch_result_t;

endpackage : duty_mon_pkg

// File: rtl/duty_mon_ch.sv
// duty_mon_ch
//   One monitored channel: counts rising edges of sig and sig_n, measures the
//   last complete high time and the last rise-to-rise period of sig, and keeps
//   a sticky flag when sig and sig_n stay equal for too long.
// Ports
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   clr      in   synchronous clear, same effect as rst
//   sig_i    in   monitored signal
//   sig_n_i  in   complement of the monitored signal
//   res_o    out  registered results (zero-extended into ch_result_t)
module duty_mon_ch
  import duty_mon_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIME_W     = TIME_W_DEF,
  parameter int DIFF_CHECK = 1,
  parameter int SKEW_MAX   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       sig_i,
  input  logic       sig_n_i,
  output ch_result_t res_o
);

  // Skew counter only needs to reach SKEW_MAX+1, where it holds.
  localparam int SKEW_W = $clog2(SKEW_MAX + 2);
  localparam logic [SKEW_W-1:0] SKEW_LIM  = SKEW_W'(SKEW_MAX + 1);
  localparam logic [SKEW_W-1:0] SKEW_TRIP = SKEW_W'(SKEW_MAX);
  localparam logic [SKEW_W-1:0] SKEW_ONE  = SKEW_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [TIME_W-1:0] TIME_ONE  = TIME_W'(1);

  logic              sig_q, sig_d;
  logic              sig_n_q, sig_n_d;
  logic              primed_q, primed_d;
  logic              armed_q, armed_d;
  logic [TIME_W-1:0] hcnt_q, hcnt_d;
  logic [TIME_W-1:0] pcnt_q, pcnt_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_n_q, cnt_n_d;
  logic [TIME_W-1:0] high_time_q, high_time_d;
  logic [TIME_W-1:0] period_q, period_d;
  logic              valid_q, valid_d;
  logic              comp_err_q, comp_err_d;

  logic rise, fall, rise_n;

  // Edges are only trusted once the sample registers hold a real previous value.
  assign rise   = primed_q & sig_i & ~sig_q;
  assign fall   = primed_q & ~sig_i & sig_q;
  assign rise_n = primed_q & sig_n_i & ~sig_n_q;

  always_comb begin
    sig_d       = sig_i;
    sig_n_d     = sig_n_i;
    primed_d    = 1'b1;
    armed_d     = armed_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    skew_d      = skew_q;
    cnt_d       = cnt_q;
    cnt_n_d     = cnt_n_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    valid_d     = valid_q;
    comp_err_d  = comp_err_q;

    if (primed_q) begin
      if (rise) begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        hcnt_d = TIME_ONE;
        if (armed_q) begin
          period_d = pcnt_q;
          valid_d  = 1'b1;
        end
        pcnt_d  = TIME_ONE;
        armed_d = 1'b1;
      end else begin
        if (sig_i && hcnt_q != '1) hcnt_d = hcnt_q + TIME_ONE;
        if (armed_q && pcnt_q != '1) pcnt_d = pcnt_q + TIME_ONE;
      end

      // Without a prior rise the pulse began before priming; drop it.
      if (fall && armed_q) high_time_d = hcnt_q;

      if (rise_n && cnt_n_q != '1) cnt_n_d = cnt_n_q + CNT_ONE;

      if (DIFF_CHECK != 0) begin
        if (sig_i == sig_n_i) begin
          if (skew_q != SKEW_LIM) skew_d = skew_q + SKEW_ONE;
          // This cycle is the (SKEW_MAX+1)-th consecutive equal sample.
          if (skew_q >= SKEW_TRIP) comp_err_d = 1'b1;
        end else begin
          skew_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sig_q       <= 1'b0;
      sig_n_q     <= 1'b0;
      primed_q    <= 1'b0;
      armed_q     <= 1'b0;
      hcnt_q      <= '0;
      pcnt_q      <= '0;
      skew_q      <= '0;
      cnt_q       <= '0;
      cnt_n_q     <= '0;
      high_time_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      comp_err_q  <= 1'b0;
    end else begin
      sig_q       <= sig_d;
      sig_n_q     <= sig_n_d;
      primed_q    <= primed_d;
      armed_q     <= armed_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      skew_q      <= skew_d;
      cnt_q       <= cnt_d;
      cnt_n_q     <= cnt_n_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      valid_q     <= valid_d;
      comp_err_q  <= comp_err_d;
    end
  end

  always_comb begin
    res_o           = '0;
    res_o.cnt       = CNT_W_MAX'(cnt_q);
    res_o.cnt_n     = CNT_W_MAX'(cnt_n_q);
    res_o.high_time = TIME_W_MAX'(high_time_q);
    res_o.period    = TIME_W_MAX'(period_q);
    res_o.valid     = valid_q;
    res_o.comp_err  = comp_err_q;
  end

endmodule : duty_mon_ch

// File: rtl/duty_monitor.sv
// duty_monitor
//   Multi-channel pulse / duty-cycle monitor. Each channel is an independent
//   duty_mon_ch instance; this level only packs the per-channel results onto
//   flat buses (channel i at [i*W +: W]).
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset (dominates clr)
//   clr        in   synchronous clear of all channel state
//   sig        in   NUM_CH monitored signals
//   sig_n      in   NUM_CH complement signals
//   cnt        out  rising edges of sig, CNT_W per channel, saturating
//   cnt_n      out  rising edges of sig_n, CNT_W per channel, saturating
//   high_time  out  last complete high pulse length in clocks, TIME_W per channel
//   period     out  last rise-to-rise distance in clocks, TIME_W per channel
//   valid      out  period holds a measurement
//   comp_err   out  sticky complement-violation flag
module duty_monitor
  import duty_mon_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIME_W     = TIME_W_DEF,
  parameter int DIFF_CHECK = 1,
  parameter int SKEW_MAX   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        sig,
  input  logic [NUM_CH-1:0]        sig_n,
  output logic [NUM_CH*CNT_W-1:0]  cnt,
  output logic [NUM_CH*CNT_W-1:0]  cnt_n,
  output logic [NUM_CH*TIME_W-1:0] high_time,
  output logic [NUM_CH*TIME_W-1:0] period,
  output logic [NUM_CH-1:0]        valid,
  output logic [NUM_CH-1:0]        comp_err
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    ch_result_t res;

    duty_mon_ch #(
      .CNT_W      (CNT_W),
      .TIME_W     (TIME_W),
      .DIFF_CHECK (DIFF_CHECK),
      .SKEW_MAX   (SKEW_MAX)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .sig_i   (sig[gi]),
      .sig_n_i (sig_n[gi]),
      .res_o   (res)
    );

    assign cnt[gi*CNT_W +: CNT_W]         = CNT_W'(res.cnt);
    assign cnt_n[gi*CNT_W +: CNT_W]       = CNT_W'(res.cnt_n);
    assign high_time[gi*TIME_W +: TIME_W] = TIME_W'(res.high_time);
    assign period[gi*TIME_W +: TIME_W]    = TIME_W'(res.period);
    assign valid[gi]                      = res.valid;
    assign comp_err[gi]                   = res.comp_err;
  end

endmodule : duty_monitor

// File: tb/tb_duty_monitor.sv
module tb_duty_monitor;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;
  localparam int TIME_W = 14;
  localparam int SKEW   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, clr;
  logic [NUM_CH-1:0]        sig, sig_n;
  logic [NUM_CH*CNT_W-1:0]  cnt, cnt_n;
  logic [NUM_CH*TIME_W-1:0] high_time, period;
  logic [NUM_CH-1:0]        valid, comp_err;

  logic [0:0] sig8, sig8_n, val8, err8;
  logic [3:0] cnt8, cnt8_n;
  logic [7:0] ht8, per8;

  duty_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIME_W(TIME_W),
                 .DIFF_CHECK(1), .SKEW_MAX(SKEW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sig(sig), .sig_n(sig_n),
    .cnt(cnt), .cnt_n(cnt_n), .high_time(high_time), .period(period),
    .valid(valid), .comp_err(comp_err));

  duty_monitor #(.NUM_CH(1), .CNT_W(4), .TIME_W(8),
                 .DIFF_CHECK(1), .SKEW_MAX(SKEW)) dut8 (
    .clk(clk), .rst(rst), .clr(clr), .sig(sig8), .sig_n(sig8_n),
    .cnt(cnt8), .cnt_n(cnt8_n), .high_time(ht8), .period(per8),
    .valid(val8), .comp_err(err8));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: records rise timestamps relative to the prime cycle and
  // derives measurements as time differences.
  typedef struct {
    int t;
    bit ps;
    bit psn;
    int rises;
    int rises_n;
    int last_rise;
    int prev_rise;
    int ht;
    int run;
    bit err;
  } mstate_t;
  mstate_t m [3];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int tmax_of(input int k);
    return (k == 2) ? 255 : (1 << TIME_W) - 1;
  endfunction

  function automatic void model_step(input int k, input bit s, input bit sn, input bit rs);
    if (rs) begin
      m[k] = '{-1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 1'b0};
      return;
    end
    m[k].t++;
    if (m[k].t == 0) begin
      m[k].ps  = s;
      m[k].psn = sn;
      return;
    end
    if (s && !m[k].ps) begin
      m[k].rises++;
      m[k].prev_rise = m[k].last_rise;
      m[k].last_rise = m[k].t;
    end
    if (!s && m[k].ps && m[k].rises > 0)
      m[k].ht = imin(m[k].t - m[k].last_rise, tmax_of(k));
    if (sn && !m[k].psn) m[k].rises_n++;
    if (s == sn) m[k].run++;
    else         m[k].run = 0;
    if (m[k].run >= SKEW + 1) m[k].err = 1'b1;
    m[k].ps  = s;
    m[k].psn = sn;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, sig[0], sig_n[0], rst || clr);
    model_step(1, sig[1], sig_n[1], rst || clr);
    model_step(2, sig8[0], sig8_n[0], rst || clr);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic get_out(input int k, output int a_cnt, output int a_cntn, output int a_ht,
                         output int a_per, output int a_val, output int a_err);
    if (k < 2) begin
      a_cnt  = int'(cnt[k*CNT_W +: CNT_W]);
      a_cntn = int'(cnt_n[k*CNT_W +: CNT_W]);
      a_ht   = int'(high_time[k*TIME_W +: TIME_W]);
      a_per  = int'(period[k*TIME_W +: TIME_W]);
      a_val  = int'(valid[k]);
      a_err  = int'(comp_err[k]);
    end else begin
      a_cnt  = int'(cnt8);
      a_cntn = int'(cnt8_n);
      a_ht   = int'(ht8);
      a_per  = int'(per8);
      a_val  = int'(val8[0]);
      a_err  = int'(err8[0]);
    end
  endtask

  task automatic check_slot(input int k);
    int a_cnt, a_cntn, a_ht, a_per, a_val, a_err;
    bit v;
    get_out(k, a_cnt, a_cntn, a_ht, a_per, a_val, a_err);
    v = (m[k].rises >= 2);
    chk($sformatf("model ch%0d cnt", k), a_cnt, imin(m[k].rises, 15));
    chk($sformatf("model ch%0d cnt_n", k), a_cntn, imin(m[k].rises_n, 15));
    chk($sformatf("model ch%0d high_time", k), a_ht, m[k].ht);
    chk($sformatf("model ch%0d period", k), a_per,
        v ? imin(m[k].last_rise - m[k].prev_rise, tmax_of(k)) : 0);
    chk($sformatf("model ch%0d valid", k), a_val, int'(v));
    chk($sformatf("model ch%0d comp_err", k), a_err, int'(m[k].err));
  endtask

  task automatic chk_ch(input string tag, input int k, input int e_cnt, input int e_cntn,
                        input int e_ht, input int e_per, input int e_val, input int e_err);
    int a_cnt, a_cntn, a_ht, a_per, a_val, a_err;
    get_out(k, a_cnt, a_cntn, a_ht, a_per, a_val, a_err);
    chk({tag, " cnt"}, a_cnt, e_cnt);
    chk({tag, " cnt_n"}, a_cntn, e_cntn);
    chk({tag, " high_time"}, a_ht, e_ht);
    chk({tag, " period"}, a_per, e_per);
    chk({tag, " valid"}, a_val, e_val);
    chk({tag, " comp_err"}, a_err, e_err);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  typedef struct {
    bit clr;
    bit s;
    bit sn;
    int e_cnt;
    int e_cntn;
    int e_err;
  } vec_t;
  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1, 1, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1, 1, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2, 1, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2, 1, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2, 2, 1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1, 0, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1, 0, 1};

    rst = 1'b1; clr = 1'b0;
    sig = 2'b00; sig_n = 2'b11;
    sig8 = 1'b0; sig8_n = 1'b1;
    repeat (3) tick();
    chk_ch("reset ch0", 0, 0, 0, 0, 0, 0, 0);
    chk_ch("reset ch1", 1, 0, 0, 0, 0, 0, 0);

    // Reset released while sig is already high: nothing is recorded.
    sig[0] = 1'b1; sig_n[0] = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("held-high cnt", int'(cnt[3:0]), 0);
      chk("held-high valid", int'(valid[0]), 0);
      chk("held-high high_time", int'(high_time[13:0]), 0);
    end
    sig[0] = 1'b0; sig_n[0] = 1'b1;
    repeat (5) tick();
    chk("first-fall high_time", int'(high_time[13:0]), 0);
    chk("first-fall cnt", int'(cnt[3:0]), 0);
    check_slot(0);

    // Square wave on ch0: 3 periods of 6250 high / 6250 low.
    do_clr();
    repeat (2) tick();
    for (int p = 0; p < 3; p++) begin
      sig[0] = 1'b1; sig_n[0] = 1'b0;
      repeat (6250) tick();
      sig[0] = 1'b0; sig_n[0] = 1'b1;
      repeat (6250) tick();
    end
    chk_ch("square ch0", 0, 3, 3, 6250, 12500, 1, 0);
    chk_ch("square ch1", 1, 0, 0, 0, 0, 0, 0);
    check_slot(0);

    // 20 pulses on ch1 saturate its counters; ch0 keeps its results.
    for (int p = 0; p < 20; p++) begin
      sig[1] = 1'b1; sig_n[1] = 1'b0;
      repeat (3) tick();
      sig[1] = 1'b0; sig_n[1] = 1'b1;
      repeat (3) tick();
    end
    chk_ch("sat ch1", 1, 15, 15, 3, 6, 1, 0);
    chk_ch("sat ch0", 0, 3, 3, 6250, 12500, 1, 0);
    check_slot(1);

    // Complement skew table on ch0, ch1 idle.
    sig[1] = 1'b0; sig_n[1] = 1'b1;
    for (int i = 0; i < 13; i++) begin
      clr = tbl[i].clr; sig[0] = tbl[i].s; sig_n[0] = tbl[i].sn;
      tick();
      chk($sformatf("skew row%0d cnt", i), int'(cnt[3:0]), tbl[i].e_cnt);
      chk($sformatf("skew row%0d cnt_n", i), int'(cnt_n[3:0]), tbl[i].e_cntn);
      chk($sformatf("skew row%0d comp_err", i), int'(comp_err[0]), tbl[i].e_err);
    end
    clr = 1'b0;
    check_slot(0);
    check_slot(1);

    // Clear in the middle of a high pulse.
    sig[0] = 1'b0; sig_n[0] = 1'b1;
    do_clr();
    tick();
    sig[0] = 1'b1; sig_n[0] = 1'b0; repeat (40) tick();
    sig[0] = 1'b0; sig_n[0] = 1'b1; repeat (40) tick();
    sig[0] = 1'b1; sig_n[0] = 1'b0; repeat (20) tick();
    chk_ch("pre-clr ch0", 0, 2, 1, 40, 80, 1, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_ch("post-clr ch0", 0, 0, 0, 0, 0, 0, 0);
    repeat (10) tick();
    sig[0] = 1'b0; sig_n[0] = 1'b1; repeat (10) tick();
    chk("partial high_time", int'(high_time[13:0]), 0);
    sig[0] = 1'b1; sig_n[0] = 1'b0; repeat (100) tick();
    sig[0] = 1'b0; sig_n[0] = 1'b1; repeat (5) tick();
    chk_ch("after-clr pulse ch0", 0, 1, 2, 100, 0, 0, 0);
    check_slot(0);

    // Period beyond the 8-bit range saturates.
    sig8 = 1'b0; sig8_n = 1'b1;
    do_clr();
    tick();
    sig8 = 1'b1; sig8_n = 1'b0; repeat (10) tick();
    sig8 = 1'b0; sig8_n = 1'b1; repeat (300) tick();
    sig8 = 1'b1; sig8_n = 1'b0; tick();
    chk_ch("tw8 sat", 2, 2, 1, 10, 255, 1, 0);
    check_slot(2);

    // Randomised run against the model.
    for (int it = 0; it < 3000; it++) begin
      clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) sig[c] = ~sig[c];
        sig_n[c] = ($urandom_range(0, 15) == 0) ? 1'($urandom_range(0, 1)) : ~sig[c];
      end
      if ($urandom_range(0, 99) == 0) sig8 = ~sig8;
      sig8_n = ($urandom_range(0, 31) == 0) ? 1'($urandom_range(0, 1)) : ~sig8;
      tick();
      check_slot(0);
      check_slot(1);
      check_slot(2);
    end
    rst = 1'b0; clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_duty_monitor
